// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply / restoring divide feeding the Z register.
// MULDIV_UNSIGNED_EN: op[1] selects unsigned operation when defined.
module mul_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic                 clock,
   input  logic                 clear,
   input  logic                 start,
   input  logic [1:0]           op,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   result,
   output logic                 div_by_zero
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIX,
      S_DONE
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [CW-1:0]    r_count;
   logic             r_div;
   logic             r_dz;
   logic             r_neg_q;
   logic             r_neg_r;
   logic [WIDTH-1:0] r_a_raw;
   logic [WIDTH-1:0] r_opd;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;

   logic             w_uns;
   logic             w_sa;
   logic             w_sb;
   logic             w_accept;
   logic [WIDTH-1:0] w_mag_a;
   logic [WIDTH-1:0] w_mag_b;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_sh;
   logic [WIDTH:0]   w_dif;
   logic             w_ge;
   logic [2*WIDTH-1:0] w_prod;
   logic [2*WIDTH-1:0] w_res;

`ifdef MULDIV_UNSIGNED_EN
   assign w_uns = op[1];
`else
   logic w_unused_op1;
   assign w_unused_op1 = op[1];
   assign w_uns        = 1'b0;
`endif

   assign w_sa     = ~w_uns & A[WIDTH-1];
   assign w_sb     = ~w_uns & B[WIDTH-1];
   assign w_mag_a  = w_sa ? -A : A;
   assign w_mag_b  = w_sb ? -B : B;
   assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);

   assign busy = (r_state == S_RUN) || (r_state == S_FIX);
   assign done = (r_state == S_DONE);

   // MUL: {hi,lo} shifts right, lo holds the multiplier bits.
   // DIV: {hi,lo} shifts left, lo collects quotient bits.
   always_comb begin
      w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opd} : '0);
      w_sh   = {r_hi, r_lo[WIDTH-1]};
      w_ge   = (w_sh >= {1'b0, r_opd});
      w_dif  = w_sh - {1'b0, r_opd};
      w_prod = {r_hi, r_lo};
      w_res  = w_prod;
      if (r_dz)
         w_res = {r_a_raw, {WIDTH{1'b1}}};
      else if (r_div)
         w_res = {(r_neg_r ? -r_hi : r_hi), (r_neg_q ? -r_lo : r_lo)};
      else if (r_neg_q)
         w_res = -w_prod;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: if (start) w_next = S_RUN;
         S_RUN:  if (r_count == CW'(WIDTH-1)) w_next = S_FIX;
         S_FIX:  w_next = S_DONE;
         S_DONE: w_next = start ? S_RUN : S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         r_count     <= '0;
         r_div       <= 1'b0;
         r_dz        <= 1'b0;
         r_neg_q     <= 1'b0;
         r_neg_r     <= 1'b0;
         r_a_raw     <= '0;
         r_opd       <= '0;
         r_hi        <= '0;
         r_lo        <= '0;
         result      <= '0;
         div_by_zero <= 1'b0;
      end else if (w_accept) begin
         r_count <= '0;
         r_div   <= op[0];
         r_dz    <= op[0] && (B == '0);
         r_neg_q <= w_sa ^ w_sb;
         r_neg_r <= w_sa;
         r_a_raw <= A;
         r_opd   <= op[0] ? w_mag_b : w_mag_a;
         r_lo    <= op[0] ? w_mag_a : w_mag_b;
         r_hi    <= '0;
      end else if (r_state == S_RUN) begin
         r_count <= r_count + CW'(1);
         if (r_div) begin
            r_hi <= w_ge ? w_dif[WIDTH-1:0] : w_sh[WIDTH-1:0];
            r_lo <= {r_lo[WIDTH-2:0], w_ge};
         end else begin
            r_hi <= w_sum[WIDTH:1];
            r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
         end
      end else if (r_state == S_FIX) begin
         result      <= w_res;
         div_by_zero <= r_dz;
      end
   end

endmodule
